// File: rtl/tmds_decoder_pkg.sv
// tmds_pkg: shared constants and types for the TMDS receive channel.
//   TMDS_SYM_W    symbol width (10 bits)
//   TMDS_CTRL_xx  the four blanking control tokens, indexed by {c1,c0}
//   tmds_state_e  alignment FSM states
package tmds_pkg;

    localparam int TMDS_SYM_W = 10;

    localparam logic [TMDS_SYM_W-1:0] TMDS_CTRL_00 = 10'b1101010100;
    localparam logic [TMDS_SYM_W-1:0] TMDS_CTRL_01 = 10'b0010101011;
    localparam logic [TMDS_SYM_W-1:0] TMDS_CTRL_10 = 10'b0101010100;
    localparam logic [TMDS_SYM_W-1:0] TMDS_CTRL_11 = 10'b1010101011;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } tmds_state_e;

endpackage

// File: rtl/tmds_decoder_if.sv
// tmds_decoder_if: raw word input and decoded symbol output of one TMDS channel.
//   master: drives raw_valid/raw, observes the decoder outputs (deserializer side / bench)
//   slave : the decoder
interface tmds_decoder_if;
    import tmds_pkg::*;

    logic                  raw_valid;
    logic [TMDS_SYM_W-1:0] raw;
    logic                  locked;
    logic [3:0]            offset;
    logic                  dout_valid;
    logic                  de;
    logic                  c0;
    logic                  c1;
    logic [7:0]            dout;
    logic                  sym_err;

    modport master (
        output raw_valid, raw,
        input  locked, offset, dout_valid, de, c0, c1, dout, sym_err
    );

    modport slave (
        input  raw_valid, raw,
        output locked, offset, dout_valid, de, c0, c1, dout, sym_err
    );

endinterface

// File: rtl/tmds_decoder_symbol_decode.sv
// tmds_symbol_decode: purely combinational decode of one aligned 10-bit symbol.
//   sym      in  10  aligned symbol, bit 0 first on the wire
//   is_token out 1   sym is one of the four control tokens
//   c1c0     out 2   control bits carried by the token (0 when not a token)
//   d        out 8   data byte undone from the transition-minimised code
//   sym_err  out 1   non-token whose bit 8 disagrees with what an encoder would emit
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [TMDS_SYM_W-1:0] sym,
    output logic                  is_token,
    output logic [1:0]            c1c0,
    output logic [7:0]            d,
    output logic                  sym_err
);

    logic [7:0] q;
    logic [3:0] ones;
    logic       b8_expected;

    always_comb begin
        is_token = 1'b1;
        c1c0     = 2'b00;
        case (sym)
            TMDS_CTRL_00: c1c0 = 2'b00;
            TMDS_CTRL_01: c1c0 = 2'b01;
            TMDS_CTRL_10: c1c0 = 2'b10;
            TMDS_CTRL_11: c1c0 = 2'b11;
            default:      is_token = 1'b0;
        endcase
    end

    always_comb begin
        q    = sym[9] ? ~sym[7:0] : sym[7:0];
        d    = 8'h00;
        d[0] = q[0];
        for (int i = 1; i < 8; i++)
            d[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        ones = 4'd0;
        for (int i = 0; i < 8; i++)
            ones = ones + {3'b000, d[i]};
        // Encoder picks XNOR (bit 8 = 0) for bytes heavy in ones.
        b8_expected = !((ones > 4'd4) || ((ones == 4'd4) && !d[0]));
        sym_err     = !is_token && (sym[8] != b8_expected);
    end

endmodule

// File: rtl/tmds_decoder.sv
// tmds_decoder: one TMDS receive channel. Finds word alignment by locking onto
// control tokens, then decodes each symbol to pixel data or c0/c1.
//   clk  in  pixel clock
//   rst  in  synchronous active-high reset
//   bus  slave side of tmds_decoder_if (raw_valid/raw in; locked, offset,
//        dout_valid, de, c0, c1, dout, sym_err out, all registered)
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_TOKENS  = 8,
    parameter int SEARCH_WORDS = 64,
    parameter int ERR_LIMIT    = 4
) (
    input  logic           clk,
    input  logic           rst,
    tmds_decoder_if.slave  bus
);

    localparam logic [1:0] S_SEARCH = SEARCH;
    localparam logic [1:0] S_VERIFY = VERIFY;
    localparam logic [1:0] S_LOCKED = LOCKED;

    localparam int TW = $clog2(LOCK_TOKENS + 1);
    localparam int SW = $clog2(SEARCH_WORDS);
    localparam int EW = $clog2(ERR_LIMIT + 1);

    localparam logic [TW-1:0] TOK_LAST  = TW'(LOCK_TOKENS - 1);
    localparam logic [SW-1:0] SRCH_LAST = SW'(SEARCH_WORDS - 1);
    localparam logic [EW-1:0] ERR_LAST  = EW'(ERR_LIMIT - 1);

    logic [1:0]            state;
    logic [TW-1:0]         tok_cnt;
    logic [SW-1:0]         srch_cnt;
    logic [EW-1:0]         err_cnt;
    logic [3:0]            offset;
    logic [TMDS_SYM_W-1:0] raw_prev;
    logic                  locked_q, dv_q, de_q, c0_q, c1_q, err_q;
    logic [7:0]            dout_q;

    // Older word sits in the low half, so the bit stream reads upward through
    // hist. At offset 0 the window is exactly the previous word, so decoded
    // output trails its input word by one extra valid word.
    logic [2*TMDS_SYM_W-1:0] hist;
    logic [TMDS_SYM_W-1:0]   sym;
    logic                    is_token, sym_err;
    logic [1:0]              c1c0;
    logic [7:0]              d;
    logic [3:0]              next_off;

    assign hist     = {bus.raw, raw_prev};
    assign sym      = hist[offset +: TMDS_SYM_W];
    assign next_off = (offset == 4'd9) ? 4'd0 : offset + 4'd1;

    tmds_symbol_decode u_dec (
        .sym      (sym),
        .is_token (is_token),
        .c1c0     (c1c0),
        .d        (d),
        .sym_err  (sym_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_SEARCH;
            tok_cnt  <= '0;
            srch_cnt <= '0;
            err_cnt  <= '0;
            offset   <= 4'd0;
            raw_prev <= '0;
            locked_q <= 1'b0;
            dv_q     <= 1'b0;
            de_q     <= 1'b0;
            c0_q     <= 1'b0;
            c1_q     <= 1'b0;
            dout_q   <= 8'h00;
            err_q    <= 1'b0;
        end else if (!bus.raw_valid) begin
            dv_q <= 1'b0;
        end else begin
            dv_q     <= locked_q;
            raw_prev <= bus.raw;
            de_q     <= !is_token;
            err_q    <= sym_err;
            if (is_token) {c1_q, c0_q} <= c1c0;
            else          dout_q       <= d;

            case (state)
                S_SEARCH: begin
                    // A token beats a terminal search count: no slip.
                    if (is_token) begin
                        state   <= S_VERIFY;
                        tok_cnt <= TW'(1);
                    end else if (srch_cnt == SRCH_LAST) begin
                        offset   <= next_off;
                        srch_cnt <= '0;
                    end else begin
                        srch_cnt <= srch_cnt + 1'b1;
                    end
                end
                S_VERIFY: begin
                    if (is_token) begin
                        if (tok_cnt == TOK_LAST) begin
                            state    <= S_LOCKED;
                            locked_q <= 1'b1;
                            tok_cnt  <= '0;
                            err_cnt  <= '0;
                        end else begin
                            tok_cnt <= tok_cnt + 1'b1;
                        end
                    end else begin
                        state   <= S_SEARCH;
                        tok_cnt <= '0;
                        if (srch_cnt != SRCH_LAST) srch_cnt <= srch_cnt + 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (is_token) begin
                        err_cnt <= '0;
                    end else if (sym_err) begin
                        if (err_cnt == ERR_LAST) begin
                            state    <= S_SEARCH;
                            locked_q <= 1'b0;
                            offset   <= next_off;
                            err_cnt  <= '0;
                            srch_cnt <= '0;
                        end else begin
                            err_cnt <= err_cnt + 1'b1;
                        end
                    end
                end
                default: state <= S_SEARCH;
            endcase
        end
    end

    assign bus.locked     = locked_q;
    assign bus.offset     = offset;
    assign bus.dout_valid = dv_q;
    assign bus.de         = de_q;
    assign bus.c0         = c0_q;
    assign bus.c1         = c1_q;
    assign bus.dout       = dout_q;
    assign bus.sym_err    = err_q;

endmodule

// File: tb/tb_tmds_decoder.sv
module tb_tmds_decoder;
    import tmds_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tmds_decoder_if bus ();

    tmds_decoder #(.LOCK_TOKENS(8), .SEARCH_WORDS(64), .ERR_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 0;

    // ---------------- behavioural model ----------------
    logic [9:0] tok_tab [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    int         m_st;          // 0 searching, 1 verifying, 2 locked
    int         m_tok, m_srch, m_errs, m_off;
    logic [9:0] m_prev;
    bit         e_locked, e_dv, e_de, e_c0, e_c1, e_err;
    logic [7:0] e_dout;
    int         e_off;

    task automatic m_reset();
        m_st = 0; m_tok = 0; m_srch = 0; m_errs = 0; m_off = 0; m_prev = '0;
        e_locked = 0; e_dv = 0; e_de = 0; e_c0 = 0; e_c1 = 0; e_err = 0;
        e_dout = 8'h00; e_off = 0;
    endtask

    task automatic m_step(input bit v, input logic [9:0] w);
        logic [19:0] h;
        logic [9:0]  s;
        logic [7:0]  q, dd;
        int          k, ones;
        bit          tok, bad, b8;
        logic [1:0]  kk;
        if (!v) begin
            e_dv = 0;
            return;
        end
        h = {w, m_prev};
        s = 10'((h >> m_off) & 20'h3FF);
        k = -1;
        for (int j = 0; j < 4; j++) if (s == tok_tab[j]) k = j;
        tok = (k >= 0);
        q = s[9] ? ~s[7:0] : s[7:0];
        dd[0] = q[0];
        for (int i = 1; i < 8; i++) dd[i] = (q[i] ^ q[i-1]) ^ !s[8];
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(dd[i]);
        b8  = (ones > 4 || (ones == 4 && dd[0] == 1'b0)) ? 1'b0 : 1'b1;
        bad = !tok && (s[8] != b8);
        e_dv  = (m_st == 2);
        e_de  = !tok;
        e_err = bad;
        if (tok) begin kk = k[1:0]; e_c1 = kk[1]; e_c0 = kk[0]; end
        else e_dout = dd;
        if (m_st == 0) begin
            if (tok) begin m_st = 1; m_tok = 1; end
            else if (m_srch == 63) begin m_off = (m_off + 1) % 10; m_srch = 0; end
            else m_srch++;
        end else if (m_st == 1) begin
            if (tok) begin
                m_tok++;
                if (m_tok == 8) begin m_st = 2; m_tok = 0; m_errs = 0; end
            end else begin
                m_st = 0; m_tok = 0;
                if (m_srch < 63) m_srch++;
            end
        end else begin
            if (tok) m_errs = 0;
            else if (bad) begin
                m_errs++;
                if (m_errs == 4) begin
                    m_st = 0; m_errs = 0; m_srch = 0; m_off = (m_off + 1) % 10;
                end
            end
        end
        e_locked = (m_st == 2);
        e_off    = m_off;
        m_prev   = w;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("locked",     int'(bus.locked),     int'(e_locked));
            check("offset",     int'(bus.offset),     e_off);
            check("dout_valid", int'(bus.dout_valid), int'(e_dv));
            check("de",         int'(bus.de),         int'(e_de));
            check("c0",         int'(bus.c0),         int'(e_c0));
            check("c1",         int'(bus.c1),         int'(e_c1));
            check("dout",       int'(bus.dout),       int'(e_dout));
            check("sym_err",    int'(bus.sym_err),    int'(e_err));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit v, input logic [9:0] w);
        bus.raw_valid = v;
        bus.raw       = w;
        @(posedge clk);
        m_step(v, w);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.raw_valid = 1'b0;
        @(posedge clk);
        m_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [9:0] table5 [9] = '{10'h100, 10'h0FF, 10'h1F0, 10'h2AB, 10'h100,
                               10'h3C3, 10'h0AB, 10'h154, 10'h0FF};
    logic [9:0] rot3;
    int         nwords;

    initial begin
        bus.raw_valid = 1'b0;
        bus.raw       = '0;
        m_reset();
        @(negedge clk);
        do_reset();
        chk_en = 1;

        // 1: aligned c=00 tokens
        for (int i = 0; i < 7; i++) step(1, 10'h354);
        check("t1_not_yet_locked", int'(bus.locked), 0);
        for (int i = 0; i < 3; i++) step(1, 10'h354);
        check("t1_locked",   int'(bus.locked), 1);
        check("t1_offset",   int'(bus.offset), 0);
        check("t1_dv",       int'(bus.dout_valid), 1);
        check("t1_de",       int'(bus.de), 0);
        check("t1_c1c0",     int'({bus.c1, bus.c0}), 0);

        // 3: data symbols; the window lags the input word by one
        step(1, 10'h100);
        step(1, 10'h0FF);
        check("t3_dout_00", int'(bus.dout), 8'h00);
        check("t3_de_00",   int'(bus.de), 1);
        check("t3_err_00",  int'(bus.sym_err), 0);
        step(1, 10'h354);
        check("t3_dout_ff", int'(bus.dout), 8'hFF);
        check("t3_err_ff",  int'(bus.sym_err), 0);

        // 4: illegal code 0x0AA repeated until lock drops
        for (int i = 0; i < 4; i++) step(1, 10'h0AA);
        check("t4_dout",        int'(bus.dout), 8'h00);
        check("t4_err",         int'(bus.sym_err), 1);
        check("t4_still_lock",  int'(bus.locked), 1);
        step(1, 10'h0AA);
        check("t4_unlocked",    int'(bus.locked), 0);
        check("t4_offset_slip", int'(bus.offset), 1);

        // 2: token stream delayed by 3 bits
        do_reset();
        rot3   = 10'((10'h354 << 3) | (10'h354 >> 7));
        nwords = 0;
        while (!bus.locked && nwords < 260) begin
            step(1, rot3);
            nwords++;
        end
        check("t2_lock_seen",   int'(bus.locked), 1);
        check("t2_lock_time",   int'(nwords <= 3 * 64 + 8), 1);
        check("t2_offset",      int'(bus.offset), 3);

        // 5: lock, data, 5-cycle gap, resume
        do_reset();
        for (int i = 0; i < 10; i++) step(1, 10'h354);
        for (int i = 0; i < 5; i++) step(1, table5[i]);
        check("t5_c1c0_11", int'({bus.c1, bus.c0}), 3);
        check("t5_de_tok",  int'(bus.de), 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 10'h3FF);
            check("t5_gap_dv", int'(bus.dout_valid), 0);
        end
        check("t5_gap_lock",   int'(bus.locked), 1);
        check("t5_gap_offset", int'(bus.offset), 0);
        for (int i = 5; i < 9; i++) step(1, table5[i]);
        step(1, 10'h354);
        check("t5_resume_dv", int'(bus.dout_valid), 1);

        // 6: reset while locked
        step(1, 10'h0FF);
        step(1, 10'h0FF);
        check("t6_pre_dout", int'(bus.dout), 8'hFF);
        do_reset();
        check("t6_locked", int'(bus.locked), 0);
        check("t6_offset", int'(bus.offset), 0);
        check("t6_dv",     int'(bus.dout_valid), 0);
        check("t6_de",     int'(bus.de), 0);
        check("t6_dout",   int'(bus.dout), 0);
        step(1, 10'h354);

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
